mux_arr_pingpong_buffer: RTL and testbench

- Two-entry ping-pong buffer placed directly upstream of the Mux2xArray2_Bits2 stage.
- Captures N-element arrays of W-bit words from a valid/ready producer into alternating banks, bank 0 then bank 1.
- Drives the 2:1 array-mux select from its read pointer to present the oldest bank to a valid/ready consumer.
- Decouples producer and consumer by up to two transfers.

---
 rtl/mux_arr_pingpong_buffer_pkg.sv | 19 +
 rtl/mux_arr_pingpong_buffer_if.sv | 38 +++
 rtl/mux_arr_pingpong_buffer_mux.sv | 28 ++
 rtl/mux_arr_pingpong_buffer.sv | 83 ++++++++
 tb/tb_mux_arr_pingpong_buffer.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/mux_arr_pingpong_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mux_arr_pingpong_buffer_pkg
//  Purpose  : Shared sizing defaults and the element-array type used by the
//             ping-pong buffer, its output mux stage and the bench.
//  Contents : c_N   - elements per transfer
//             c_W   - bits per element
//             elemArr_t - c_N x c_W unpacked element array
//  Revision : 1.0 - initial release
// ============================================================================
package mux_arr_pingpong_buffer_pkg;

  localparam int c_N = 2;
  localparam int c_W = 2;

  typedef logic [c_W-1:0] elemArr_t [c_N];

endpackage
`default_nettype wire

// File: rtl/mux_arr_pingpong_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : mux_arr_pingpong_buffer_if
//  Purpose  : Producer/consumer valid-ready bundle for the ping-pong buffer.
//  Signals  : in_data/in_valid/in_ready     - producer side
//             out_data/out_valid/out_ready  - consumer side
//             occupancy                     - number of full banks (0..2)
//  Modports : master - environment (drives in_*, out_ready)
//             slave  - buffer      (drives in_ready, out_*, occupancy)
//  Revision : 1.0 - initial release
// ============================================================================
interface mux_arr_pingpong_buffer_if
  import mux_arr_pingpong_buffer_pkg::*;
#(
  parameter int N = c_N,
  parameter int W = c_W
);

  logic [W-1:0] in_data  [N];
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data [N];
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   occupancy;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, occupancy
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, occupancy
  );

endinterface
`default_nettype wire

// File: rtl/mux_arr_pingpong_buffer_mux.sv
`default_nettype none
// ============================================================================
//  Module   : Mux2xArray2_Bits2
//  Purpose  : 2:1 selector between two N x W element arrays.
//  Ports    : I0 - array selected when S = 0
//             I1 - array selected when S = 1
//             S  - select
//             O  - selected array
//  Revision : 1.0 - generalised to N elements of W bits
// ============================================================================
module Mux2xArray2_Bits2
  import mux_arr_pingpong_buffer_pkg::*;
#(
  parameter int N = c_N,
  parameter int W = c_W
) (
  input  wire logic [W-1:0] I0 [N],
  input  wire logic [W-1:0] I1 [N],
  input  wire logic         S,
  output logic      [W-1:0] O  [N]
);

  for (genvar gi = 0; gi < N; gi++) begin : g_elem
    assign O[gi] = S ? I1[gi] : I0[gi];
  end

endmodule
`default_nettype wire

// File: rtl/mux_arr_pingpong_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : mux_arr_pingpong_buffer
//  Purpose  : Two-bank ping-pong buffer in front of the Mux2xArray2_Bits2
//             stage. Arrays are written to alternating banks and presented
//             oldest-first; the read pointer drives the mux select.
//  Ports    : CLK        - clock, rising edge
//             ASYNCRESET - asynchronous active-high reset
//             bus        - valid/ready bundle (slave modport)
//  Revision : 1.0 - initial release
// ============================================================================
module mux_arr_pingpong_buffer
  import mux_arr_pingpong_buffer_pkg::*;
#(
  parameter int N = c_N,
  parameter int W = c_W
) (
  input wire logic                 CLK,
  input wire logic                 ASYNCRESET,
  mux_arr_pingpong_buffer_if.slave bus
);

  logic [W-1:0] r_bank0  [N];
  logic [W-1:0] r_bank1  [N];
  logic [1:0]   r_full;
  logic         r_wrPtr;
  logic         r_rdPtr;

  logic         w_inReady;
  logic         w_outValid;
  logic         w_wrEn;
  logic         w_rdEn;
  logic [W-1:0] w_muxOut [N];

  assign w_inReady  = !r_full[r_wrPtr];
  assign w_outValid =  r_full[r_rdPtr];
  assign w_wrEn     = bus.in_valid  && w_inReady;
  assign w_rdEn     = bus.out_ready && w_outValid;

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = w_outValid;
  assign bus.occupancy = {1'b0, r_full[0]} + {1'b0, r_full[1]};
  assign bus.out_data  = w_muxOut;

  // Write and read can never hit the same bank in one cycle: a write needs
  // full[wrPtr]=0 and a read needs full[rdPtr]=1, so equal pointers cannot
  // both be enabled. The two flag updates therefore never collide.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      for (int i = 0; i < N; i++) begin
        r_bank0[i] <= '0;
        r_bank1[i] <= '0;
      end
      r_full  <= 2'b00;
      r_wrPtr <= 1'b0;
      r_rdPtr <= 1'b0;
    end else begin
      if (w_wrEn) begin
        if (r_wrPtr) r_bank1 <= bus.in_data;
        else         r_bank0 <= bus.in_data;
        r_full[r_wrPtr] <= 1'b1;
        r_wrPtr         <= ~r_wrPtr;
      end
      // Reading only drops the flag; bank data stays as stale content.
      if (w_rdEn) begin
        r_full[r_rdPtr] <= 1'b0;
        r_rdPtr         <= ~r_rdPtr;
      end
    end
  end

  Mux2xArray2_Bits2 #(
    .N (N),
    .W (W)
  ) u_outMux (
    .I0 (r_bank0),
    .I1 (r_bank1),
    .S  (r_rdPtr),
    .O  (w_muxOut)
  );

endmodule
`default_nettype wire

// File: tb/tb_mux_arr_pingpong_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_arr_pingpong_buffer
//  Purpose  : Self-checking bench for mux_arr_pingpong_buffer. A two-deep
//             FIFO queue model supplies expected handshake, occupancy and
//             data; directed steps add hand-computed literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux_arr_pingpong_buffer;
  import mux_arr_pingpong_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vecCnt = 0;
  int   errCnt = 0;
  bit   chkOn  = 1'b0;

  elemArr_t modelQ [$];
  elemArr_t zeroArr;

  mux_arr_pingpong_buffer_if #(.N(c_N), .W(c_W)) bus ();

  mux_arr_pingpong_buffer #(.N(c_N), .W(c_W)) dut (
    .CLK        (clk),
    .ASYNCRESET (rst),
    .bus        (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic elemArr_t mk(input int e0, input int e1);
    elemArr_t a;
    a[0] = c_W'(e0);
    a[1] = c_W'(e1);
    return a;
  endfunction

  function automatic logic [31:0] pk(input elemArr_t a);
    logic [31:0] v = '0;
    for (int i = 0; i < c_N; i++) v[i*c_W +: c_W] = a[i];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCnt++;
    if (act !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue model: updated on each rising edge from the inputs present there.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        modelQ.delete();
      end else begin
        bit wr;
        bit rd;
        wr = bus.in_valid  && (modelQ.size() < 2);
        rd = bus.out_ready && (modelQ.size() > 0);
        if (rd) void'(modelQ.pop_front());
        if (wr) modelQ.push_back(bus.in_data);
      end
    end
  end

  // Compare process: every falling edge outside reset.
  initial begin
    forever begin
      @(negedge clk);
      if (chkOn && !rst) begin
        check("mdl_in_ready",  {31'd0, bus.in_ready},  {31'd0, modelQ.size() < 2});
        check("mdl_out_valid", {31'd0, bus.out_valid}, {31'd0, modelQ.size() > 0});
        check("mdl_occupancy", {30'd0, bus.occupancy}, 32'(modelQ.size()));
        if (modelQ.size() > 0)
          check("mdl_out_data", pk(bus.out_data), pk(modelQ[0]));
      end
    end
  end

  // Inputs applied 2 time units after a rising edge, then one edge passes.
  task automatic step(input bit iv, input elemArr_t d, input bit ordy);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    @(posedge clk);
    #2;
  endtask

  task automatic checkIdle(input string tag);
    check({tag, "_in_ready"},  {31'd0, bus.in_ready},  32'd1);
    check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_occ"},       {30'd0, bus.occupancy}, 32'd0);
  endtask

  initial begin
    zeroArr       = mk(0, 0);
    bus.in_valid  = 1'b0;
    bus.in_data   = zeroArr;
    bus.out_ready = 1'b0;

    // 1. asynchronous reset takes effect before any clock edge
    #1 rst = 1'b1;
    #1;
    checkIdle("rst");
    check("rst_out_data", pk(bus.out_data), 32'h0);
    @(posedge clk); #2;
    rst   = 1'b0;
    chkOn = 1'b1;

    // 2. single transfer
    step(1'b1, mk(2, 1), 1'b0);
    check("t2_out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("t2_out_data",  pk(bus.out_data), 32'h6);   // elem0=2, elem1=1
    check("t2_occ",       {30'd0, bus.occupancy}, 32'd1);
    step(1'b0, zeroArr, 1'b1);
    check("t2_occ_drained", {30'd0, bus.occupancy}, 32'd0);
    check("t2_valid_drained", {31'd0, bus.out_valid}, 32'd0);

    // 3. fill and backpressure
    step(1'b1, mk(3, 0), 1'b0);
    step(1'b1, mk(1, 2), 1'b0);
    check("t3_occ_full",  {30'd0, bus.occupancy}, 32'd2);
    check("t3_in_ready",  {31'd0, bus.in_ready},  32'd0);
    step(1'b1, mk(2, 2), 1'b0);
    check("t3_occ_hold",  {30'd0, bus.occupancy}, 32'd2);
    check("t3_head",      pk(bus.out_data), 32'h3);   // {3,0}
    step(1'b0, zeroArr, 1'b1);
    check("t3_second",    pk(bus.out_data), 32'h9);   // {1,2}
    check("t3_occ_one",   {30'd0, bus.occupancy}, 32'd1);
    step(1'b0, zeroArr, 1'b1);
    check("t3_occ_empty", {30'd0, bus.occupancy}, 32'd0);

    // 4. simultaneous read and write at occupancy 1
    step(1'b1, mk(0, 1), 1'b0);
    check("t4_pre",       pk(bus.out_data), 32'h4);   // {0,1}
    step(1'b1, mk(2, 3), 1'b1);
    check("t4_occ",       {30'd0, bus.occupancy}, 32'd1);
    check("t4_data",      pk(bus.out_data), 32'hE);   // {2,3}
    step(1'b0, zeroArr, 1'b1);

    // 5. reset mid-operation with both banks full
    step(1'b1, mk(1, 1), 1'b0);
    step(1'b1, mk(2, 2), 1'b0);
    check("t5_occ_full",  {30'd0, bus.occupancy}, 32'd2);
    bus.in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    checkIdle("t5_rst");
    check("t5_zero_data", pk(bus.out_data), 32'h0);
    rst = 1'b0;
    step(1'b1, mk(3, 3), 1'b0);
    check("t5_wr_data",   pk(bus.out_data), 32'hF);
    step(1'b0, zeroArr, 1'b1);
    // read pointer now selects bank 1, still zero since the reset
    check("t5_bank1_zero", pk(bus.out_data), 32'h0);

    // 6. random stress against the queue model
    for (int i = 0; i < 1000; i++)
      step(1'($urandom_range(0, 1)),
           mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 3))),
           1'($urandom_range(0, 1)));

    step(1'b0, zeroArr, 1'b1);
    step(1'b0, zeroArr, 1'b1);
    step(1'b0, zeroArr, 1'b0);
    @(negedge clk);
    chkOn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule
`default_nettype wire
